// File: rtl/data_sram_resp_pkg.sv
// Shared defaults, size encodings and queue entry type for the data SRAM responder.
// Imported by the top level and by the response queue.
package data_sram_resp_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_QDEPTH  = 2;
    localparam int MAX_QDEPTH  = 4;

    localparam int CD_W  = 3;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic            is_read;
        logic [31:0]     word;
        logic [CD_W-1:0] cd;
    } resp_entry_t;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/data_sram_resp_queue.sv
// In-order response FIFO; every entry counts down to the cycle it may leave.
// The head pops when valid with countdown zero.
module resp_queue
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH   = DEF_QDEPTH,
    parameter int CD_INIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_is_read,
    input  logic [31:0]      push_word,
    output logic             pop,
    output logic             pop_is_read,
    output logic [31:0]      pop_word,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CD_W-1:0]  CD_START = CD_W'(CD_INIT);

    resp_entry_t      ent_q [MAX_QDEPTH];
    resp_entry_t      ent_d [MAX_QDEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop         = (count_q != '0) && (ent_q[head_q].cd == '0);
        pop_is_read = ent_q[head_q].is_read;
        pop_word    = ent_q[head_q].word;
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        for (int i = 0; i < MAX_QDEPTH; i++) begin
            if (ent_q[i].cd != '0) begin
                ent_d[i].cd = ent_q[i].cd - 1'b1;
            end
        end
        if (push) begin
            ent_d[tail_q] = '{is_read: push_is_read, word: push_word, cd: CD_START};
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_QDEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM with fixed-latency, in-order responses on an addr_ok/data_ok handshake.
// Queue entries hand off to a registered output stage one cycle before data_ok.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int QDEPTH  = DEF_QDEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int               WORDS    = 1 << ADDR_W;
    localparam bit               DIRECT   = (LATENCY == 1);
    localparam int               QCD_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

    logic [31:0]       mem_q [WORDS];
    logic [31:0]       mem_d;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       cur_word;
    logic              accept;
    logic              push;
    logic              q_pop;
    logic              q_pop_is_read;
    logic [31:0]       q_pop_word;
    logic [CNT_W-1:0]  q_count;
    logic              data_ok_q;
    logic              data_ok_d;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              addr_size_unused;

    assign word_idx          = data_sram_addr[ADDR_W+1:2];
    assign cur_word          = mem_q[word_idx];
    assign mem_d             = merge_lanes(cur_word, data_sram_wdata, data_sram_wstrb);
    assign data_sram_addr_ok = (q_count < QDEPTH_C);
    assign accept            = data_sram_req && data_sram_addr_ok && !reset;
    assign push              = accept && !DIRECT;

    assign addr_size_unused = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]}
                            ^ (data_sram_size inside {SIZE_BYTE, SIZE_HALF, SIZE_WORD});

    // The array keeps its contents across reset so accepted writes survive.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            mem_q[word_idx] <= mem_d;
        end
    end

    resp_queue #(
        .DEPTH   (QDEPTH),
        .CD_INIT (QCD_INIT)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_is_read (!data_sram_wr),
        .push_word    (cur_word),
        .pop          (q_pop),
        .pop_is_read  (q_pop_is_read),
        .pop_word     (q_pop_word),
        .count        (q_count)
    );

    always_comb begin
        data_ok_d = 1'b0;
        rdata_d   = '0;
        if (DIRECT) begin
            data_ok_d = accept;
            rdata_d   = (accept && !data_sram_wr) ? cur_word : '0;
        end else if (q_pop) begin
            data_ok_d = 1'b1;
            rdata_d   = q_pop_is_read ? q_pop_word : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: default instance (LATENCY 2, QDEPTH 2)
// and a LATENCY 3 / QDEPTH 2 instance for throughput and mid-run reset.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        req3, wr3;
    logic [1:0]  size3;
    logic [31:0] addr3, wdata3;
    logic [3:0]  wstrb3;
    logic        aok3, dok3;
    logic [31:0] rdata3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(10), .LATENCY(2), .QDEPTH(2)) dut (
        .clk(clk), .reset(rst),
        .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
        .data_sram_addr_ok(aok), .data_sram_data_ok(dok), .data_sram_rdata(rdata)
    );

    data_sram_resp #(.ADDR_W(10), .LATENCY(3), .QDEPTH(2)) dut3 (
        .clk(clk), .reset(rst),
        .data_sram_req(req3), .data_sram_wr(wr3), .data_sram_size(size3),
        .data_sram_addr(addr3), .data_sram_wstrb(wstrb3), .data_sram_wdata(wdata3),
        .data_sram_addr_ok(aok3), .data_sram_data_ok(dok3), .data_sram_rdata(rdata3)
    );

    // One request on the default instance; returns the response word.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output bit ok);
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        @(negedge clk);
        req = 1'b0; wr = 1'b0; wstrb = 4'h0;
        ok = 1'b0; rd = '0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (dok) begin ok = 1'b1; rd = rdata; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (dok !== 1'b0) begin n_err++; $display("FAIL rst_dok: got %b want 0", dok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_cmp++; if (dok3 !== 1'b0) begin n_err++; $display("FAIL rst_dok3: got %b want 0", dok3); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL rst_aok: got %b want 1", aok); end
        n_cmp++; if (aok3 !== 1'b1) begin n_err++; $display("FAIL rst_aok3: got %b want 1", aok3); end
        n_cmp++; if (dok !== 1'b0) begin n_err++; $display("FAIL rst_dok_post: got %b want 0", dok); end
    endtask

    task automatic test_write_read();
        req = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (dok !== 1'b0) begin n_err++; $display("FAIL wr_early: got %b want 0", dok); end
        n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL wr_aok: got %b want 1", aok); end
        wr = 1'b0; wstrb = 4'h0;
        @(negedge clk);
        req = 1'b0;
        n_cmp++; if (dok !== 1'b1) begin n_err++; $display("FAIL wr_resp_ok: got %b want 1", dok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL wr_resp_data: got %h want 0", rdata); end
        @(negedge clk);
        n_cmp++; if (dok !== 1'b1) begin n_err++; $display("FAIL rd_resp_ok: got %b want 1", dok); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_resp_data: got %h want deadbeef", rdata); end
        @(negedge clk);
        n_cmp++; if (dok !== 1'b0) begin n_err++; $display("FAIL rd_idle_ok: got %b want 0", dok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rd_idle_data: got %h want 0", rdata); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        bit ok;
        xact(1'b1, 32'h40, 4'hF, 32'h11223344, rd, ok);
        size = 2'd0;
        xact(1'b1, 32'h40, 4'b0100, 32'h00AB0000, rd, ok);
        n_cmp++; if (!ok || rd !== 32'h0) begin n_err++; $display("FAIL byte_wr_resp: ok %0d got %h want 0", ok, rd); end
        xact(1'b0, 32'h40, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'h11AB3344) begin n_err++; $display("FAIL byte_rd: ok %0d got %h want 11ab3344", ok, rd); end
        size = 2'd2;
        xact(1'b1, 32'h40, 4'b0011, 32'hFFFF5566, rd, ok);
        xact(1'b0, 32'h40, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'h11AB5566) begin n_err++; $display("FAIL half_rd: ok %0d got %h want 11ab5566", ok, rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        bit ok;
        xact(1'b0, 32'h1000_0010, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL alias_hi: ok %0d got %h want deadbeef", ok, rd); end
        xact(1'b0, 32'h13, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL alias_lo: ok %0d got %h want deadbeef", ok, rd); end
        xact(1'b1, 32'hFFFF_F014, 4'hF, 32'h5A5A1234, rd, ok);
        xact(1'b0, 32'h14, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'h5A5A1234) begin n_err++; $display("FAIL alias_wr: ok %0d got %h want 5a5a1234", ok, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp_d;
        bit ok;
        logic exp_ok;
        for (int k = 0; k < 4; k++) begin
            xact(1'b1, 32'(k * 4), 4'hF, 32'hB0B00000 + 32'(k), rd, ok);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL b2b_aok[%0d]: got %b want 1", k, aok); end
                req = 1'b1; wr = 1'b0; addr = 32'(k * 4);
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            exp_ok = (k >= 1 && k <= 4);
            exp_d  = exp_ok ? 32'hB0B00000 + 32'(k - 1) : 32'h0;
            n_cmp++; if (dok !== exp_ok) begin n_err++; $display("FAIL b2b_dok[%0d]: got %b want %b", k, dok, exp_ok); end
            n_cmp++; if (rdata !== exp_d) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rdata, exp_d); end
        end
    endtask

    task automatic test_lat3_throughput();
        logic [10:0] exp_aok;
        logic [10:0] exp_dok;
        int n;
        int r;
        bit acc;
        exp_aok = 11'b11101101101;
        exp_dok = 11'b01101101100;
        for (int j = 0; j < 7; j++) begin
            req3 = 1'b1; wr3 = 1'b1; wstrb3 = 4'hF;
            addr3  = (j < 6) ? 32'(j * 4) : 32'h20;
            wdata3 = (j < 6) ? 32'hC3C30000 + 32'(j) : 32'hCAFEF00D;
            @(negedge clk);
            req3 = 1'b0; wr3 = 1'b0; wstrb3 = 4'h0;
            repeat (4) @(negedge clk);
        end
        n = 0;
        r = 0;
        for (int k = 0; k < 11; k++) begin
            if (n < 6) begin
                req3 = 1'b1; wr3 = 1'b0; addr3 = 32'(n * 4);
            end else begin
                req3 = 1'b0;
            end
            acc = req3 && aok3;
            @(negedge clk);
            if (acc) n++;
            n_cmp++; if (aok3 !== exp_aok[k]) begin n_err++; $display("FAIL l3_aok[%0d]: got %b want %b", k, aok3, exp_aok[k]); end
            n_cmp++; if (dok3 !== exp_dok[k]) begin n_err++; $display("FAIL l3_dok[%0d]: got %b want %b", k, dok3, exp_dok[k]); end
            if (dok3 === 1'b1) begin
                n_cmp++; if (rdata3 !== 32'hC3C30000 + 32'(r)) begin n_err++; $display("FAIL l3_order[%0d]: got %h want %h", r, rdata3, 32'hC3C30000 + 32'(r)); end
                r++;
            end
        end
        req3 = 1'b0;
        n_cmp++; if (r !== 6) begin n_err++; $display("FAIL l3_resp_count: got %0d want 6", r); end
        n_cmp++; if (n !== 6) begin n_err++; $display("FAIL l3_accept_count: got %0d want 6", n); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bit ok;
        bit seen;
        req3 = 1'b1; wr3 = 1'b0; addr3 = 32'h20;
        @(negedge clk);
        addr3 = 32'h24;
        @(negedge clk);
        req3 = 1'b0;
        n_cmp++; if (dok3 !== 1'b0) begin n_err++; $display("FAIL mid_pre_dok: got %b want 0", dok3); end
        rst = 1'b1;
        #1;
        n_cmp++; if (aok3 !== 1'b1) begin n_err++; $display("FAIL mid_rst_aok: got %b want 1", aok3); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dok3 === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL mid_stale_dok: got 1 want 0"); end
        n_cmp++; if (aok3 !== 1'b1) begin n_err++; $display("FAIL mid_post_aok: got %b want 1", aok3); end
        req3 = 1'b1; wr3 = 1'b0; addr3 = 32'h20;
        @(negedge clk);
        req3 = 1'b0;
        ok = 1'b0; rd = '0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (dok3) begin ok = 1'b1; rd = rdata3; end
            @(negedge clk);
        end
        n_cmp++; if (!ok || rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL mid_keep_mem: ok %0d got %h want cafef00d", ok, rd); end
        xact(1'b0, 32'h40, 4'h0, 32'h0, rd, ok);
        n_cmp++; if (!ok || rd !== 32'h11AB5566) begin n_err++; $display("FAIL mid_keep_mem0: ok %0d got %h want 11ab5566", ok, rd); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wstrb = '0; wdata = '0;
        req3 = 1'b0; wr3 = 1'b0; size3 = 2'd2; addr3 = '0; wstrb3 = '0; wdata3 = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_alias();
        test_back_to_back();
        test_lat3_throughput();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
